// File: rtl/axis_pkg.sv
// Shared AXI-stream definitions: keep-width helper and the reference beat layout.
package axis_pkg;

    // Number of tkeep bits for a given tdata width (one per byte lane).
    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

    localparam int AXIS_DATA_WIDTH = 32;
    localparam int AXIS_USER_WIDTH = 1;
    localparam int AXIS_KEEP_WIDTH = keep_width(AXIS_DATA_WIDTH);

    // Beat layout for the default configuration; modules rebuild the same
    // field order from their own parameters.
    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] data;
        logic [AXIS_KEEP_WIDTH-1:0] keep;
        logic [AXIS_USER_WIDTH-1:0] user;
        logic                       last;
    } axis_beat_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// Beat storage for axis_fifo: register array, one write port, asynchronous read.
module axis_fifo_mem #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_fifo.sv
// AXI-stream FIFO with first-word-fall-through output and optional
// store-and-forward packet mode that releases data only on complete packets.
module axis_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int USER_WIDTH  = 1,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             s_tdata,
    input  logic [keep_width(DATA_WIDTH)-1:0] s_tkeep,
    input  logic [USER_WIDTH-1:0]             s_tuser,
    input  logic                              s_tlast,
    input  logic                              s_tvalid,
    output logic                              s_tready,
    output logic [DATA_WIDTH-1:0]             m_tdata,
    output logic [keep_width(DATA_WIDTH)-1:0] m_tkeep,
    output logic [USER_WIDTH-1:0]             m_tuser,
    output logic                              m_tlast,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic [$clog2(DEPTH):0]            level,
    output logic [$clog2(DEPTH):0]            pkt_count
);

    localparam int KEEP_WIDTH = keep_width(DATA_WIDTH);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic [USER_WIDTH-1:0] user;
        logic                  last;
    } beat_t;

    localparam int BEAT_WIDTH = $bits(beat_t);

    generate
        if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_data_width
            $error("axis_fifo: DATA_WIDTH must be a multiple of 8 and at least 8");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("axis_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr_next;
    logic [PTR_WIDTH-1:0] rd_ptr_next;
    logic                 push;
    logic                 pop;
    logic                 empty;
    logic                 full;
    logic                 full_next;
    logic                 flush;
    beat_t                wr_beat;
    beat_t                rd_beat;

    assign push  = s_tvalid && s_tready;
    assign pop   = m_tvalid && m_tready;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

    assign wr_ptr_next = wr_ptr + {{ADDR_WIDTH{1'b0}}, push};
    assign rd_ptr_next = rd_ptr + {{ADDR_WIDTH{1'b0}}, pop};
    // Ready is registered from next-state fullness, so a pop while full only
    // reopens the input on the following cycle and m_tready never reaches s_tready.
    assign full_next = (wr_ptr_next[ADDR_WIDTH-1:0] == rd_ptr_next[ADDR_WIDTH-1:0]) &&
                       (wr_ptr_next[ADDR_WIDTH] != rd_ptr_next[ADDR_WIDTH]);

    assign level = wr_ptr - rd_ptr;

    // In packet mode, hold output until a whole packet is stored, unless the
    // FIFO filled without one (oversize packet), in which case cut through.
    assign m_tvalid = !empty && ((PACKET_MODE == 0) || (pkt_count != '0) || flush);

    assign wr_beat = '{data: s_tdata, keep: s_tkeep, user: s_tuser, last: s_tlast};
    assign m_tdata = rd_beat.data;
    assign m_tkeep = rd_beat.keep;
    assign m_tuser = rd_beat.user;
    assign m_tlast = rd_beat.last;

    axis_fifo_mem #(
        .WIDTH (BEAT_WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .we      (push),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_beat),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (rd_beat)
    );

    // Advance pointers on push/pop and register the input-side ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            s_tready <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_next;
            rd_ptr   <= rd_ptr_next;
            s_tready <= !full_next;
        end
    end

    // Count tlast beats currently held; simultaneous in and out cancel.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pkt_count <= '0;
        end else begin
            case ({push && s_tlast, pop && m_tlast})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    // Flush opens the output for an oversize packet and closes at its tlast.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush <= 1'b0;
        end else if (pop && m_tlast) begin
            flush <= 1'b0;
        end else if (full && (pkt_count == '0)) begin
            flush <= 1'b1;
        end
    end

endmodule

// File: doc/axis_fifo.md
Name: axis_fifo

Overview:
- Parametrised AXI-stream FIFO, the next generation of the team's AXI-stream plumbing: configurable data width, per-byte TKEEP, multi-bit TUSER and depth.
- Optional store-and-forward packet mode holds output until a complete TLAST-terminated packet is buffered.
- Sits between stream producers and consumers (e.g. pixel ingest -> conv layer) to absorb backpressure and decouple bursts.

Parameters:
- DATA_WIDTH, 32, tdata width in bits; must be a multiple of 8, >= 8
- USER_WIDTH, 1, tuser width in bits, >= 1
- DEPTH, 16, storage entries; power of two, >= 2
- PACKET_MODE, 0, 0 = first-word-fall-through streaming; 1 = store-and-forward on tlast

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- s_tdata  in  DATA_WIDTH  slave payload
- s_tkeep  in  DATA_WIDTH/8  slave per-byte keep
- s_tuser  in  USER_WIDTH  slave sideband
- s_tlast  in  1  slave end of packet
- s_tvalid  in  1  slave valid
- s_tready  out  1  slave ready
- m_tdata  out  DATA_WIDTH  master payload
- m_tkeep  out  DATA_WIDTH/8  master keep
- m_tuser  out  USER_WIDTH  master sideband
- m_tlast  out  1  master end of packet
- m_tvalid  out  1  master valid
- m_tready  in  1  master ready
- level  out  $clog2(DEPTH)+1  entries currently stored
- pkt_count  out  $clog2(DEPTH)+1  complete packets stored (tlast beats in FIFO)

Behaviour:
- Reset (reset=0, async): wr/rd pointers, level, pkt_count and flush flag go to 0; s_tready=0; m_tvalid=0. s_tready is registered and rises on the first clock edge after reset deasserts. Storage is not reset. m_tdata/m_tkeep/m_tuser/m_tlast are don't-care while m_tvalid=0.
- Reset mid-operation discards all contents immediately; no partial beat is emitted.
- Push = s_tvalid && s_tready; pop = m_tvalid && m_tready. Beat is {tdata, tkeep, tuser, tlast}, stored and returned bit-exact.
- Pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit. Empty = pointers equal. Full = addresses equal with wrap bits differing.
- s_tready = !full, registered. No combinational path from m_tready to s_tready. When full, a pop in the same cycle does not enable a push; s_tready rises the cycle after the pop.
- Latency: a beat pushed at edge N is visible on m_* at edge N+1 when streaming, i.e. m_tvalid is high in the following cycle. No same-cycle bypass from an empty FIFO.
- level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Master payload holds stable while m_tvalid && !m_tready (AXI-stream rule). m_tvalid never drops without a pop.
- pkt_count: +1 on push with s_tlast, -1 on pop with m_tlast, unchanged if both occur. It is maintained in both modes.
- PACKET_MODE=0: m_tvalid = !empty.
- PACKET_MODE=1: m_tvalid = !empty && (pkt_count != 0 || flush).
  - flush sets when full && pkt_count == 0, so an oversize packet cuts through instead of deadlocking.
  - flush clears on pop of a beat with tlast.
  - After the last tlast beat pops, m_tvalid drops the next cycle if no further complete packet is stored.
- Upstream protocol violations (payload changing while stalled) are not detected.

Decomposition:
- Shared package axis_pkg:
  - beat struct typedef parametrised via localparams (data, keep, user, last).
  - Function keep_width(DATA_WIDTH) = DATA_WIDTH/8.
- Sub-module axis_fifo_mem:
  - DEPTH x beat-width register array.
  - Write port at wr_addr on we; asynchronous read at rd_addr.
- axis_fifo holds pointers, flags, counters and packet-mode gating.
- Elaboration-time assertions: DATA_WIDTH%8==0; DEPTH is a power of two.

Test Plan:
- Stream: DATA_WIDTH=32, DEPTH=8, PACKET_MODE=0, push 0x00000001..0x00000014 with random m_tready -> identical output order, level never exceeds 8, no data loss.
- Full boundary: m_tready=0, push 9 beats -> s_tready=0 after the 8th accept, level=8. Assert m_tready one cycle -> level=7, s_tready=1 the following cycle.
- Packet mode: push 3-beat packet (tlast on beat 3, tkeep 4'hF,4'hF,4'h3, tuser 1,0,0) -> m_tvalid stays 0 until the cycle after beat 3 push, then 3 beats out with matching tkeep/tuser, pkt_count 1 -> 0.
- Oversize packet: PACKET_MODE=1, DEPTH=8, 12-beat packet -> flush at level=8 with pkt_count=0, all 12 beats delivered in order, m_tvalid low after final tlast pop.
- Simultaneous push and pop at level=4 with tlast on both beats -> level stays 4, pkt_count unchanged.
- Async reset asserted mid-packet at level=5 -> m_tvalid=0, level=0, pkt_count=0 without a clock edge. s_tready=1 one edge after release, and the next pushed beat emerges first.
